// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front end. It streams sequential word fetches to a
// synchronous instruction ROM and queues the returned words, with their byte
// PCs, in a small FIFO. The core drains the FIFO through a valid/ready
// handshake. A redirect flushes the FIFO, squashes any fetch still in flight,
// and restarts fetching at the word-aligned target.
//
// Parameters
//   RESET_PC  byte address fetched first after reset
//   DEPTH     output queue entries (2, 4 or 8)
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             asynchronous active-low reset
//   rom_addr[11:0]  word address to the ROM (fpc[13:2])
//   rom_req         rom_addr is a live fetch this cycle
//   rom_q[31:0]     ROM data, valid the cycle after the sampling edge
//   redirect_valid  redirect request from the core
//   redirect_pc     redirect target byte address
//   out_valid       {pc_out, instr_out} holds a valid instruction
//   out_ready       core accepts the instruction
//   pc_out[31:0]    byte address of instr_out
//   instr_out[31:0] fetched instruction word
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] rom_addr,
    output logic        rom_req,
    input  logic [31:0] rom_q,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   r_fpc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];

    logic          w_deq;
    logic          w_enq;
    logic          w_issue;
    logic [CW:0]   w_used;
    logic [31:0]   w_redirect_target;

    // Slots already promised: queued entries plus the response in flight,
    // minus the entry leaving this cycle. Never underflows because a dequeue
    // implies a non-empty queue.
    assign w_used = {1'b0, r_count}
                  + {{CW{1'b0}}, r_inflight}
                  - {{CW{1'b0}}, w_deq};

    // A fetch is only issued when its response is guaranteed a queue slot,
    // so the queue can never be written while full. Held off during reset.
    assign w_issue = rst & ~redirect_valid & (w_used < DEPTH_W);

    // The response of last cycle's fetch lands now unless a redirect squashes it.
    assign w_enq = r_inflight & ~redirect_valid;

    assign out_valid = (r_count != {CW{1'b0}}) & ~redirect_valid;
    assign w_deq     = out_valid & out_ready;

    assign rom_addr  = r_fpc[13:2];
    assign rom_req   = w_issue;
    assign pc_out    = r_q_pc[r_rd_ptr];
    assign instr_out = r_q_instr[r_rd_ptr];

    // Redirect targets are forced to a word boundary.
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Fetch PC, in-flight tracking, queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fpc      <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_count    <= {CW{1'b0}};
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
        end else if (redirect_valid) begin
            r_fpc      <= w_redirect_target;
            r_inflight <= 1'b0;
            r_count    <= {CW{1'b0}};
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
        end else begin
            if (w_issue) begin
                r_fpc      <= r_fpc + 32'd4;
                r_req_pc   <= r_fpc;
                r_inflight <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
            end
            r_count <= r_count + {{PW{1'b0}}, w_enq} - {{PW{1'b0}}, w_deq};
        end
    end

    // Queue storage; pointers and count qualify validity, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_pc[r_wr_ptr]    <= r_req_pc;
            r_q_instr[r_wr_ptr] <= rom_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0, DEPTH = 4)
    logic        rst;
    logic [11:0] rom_addr;
    logic        rom_req;
    logic [31:0] rom_q;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    // Second DUT for the 16 KiB wrap case
    logic        rst1;
    logic [11:0] rom_addr1;
    logic        rom_req1;
    logic [31:0] rom_q1;
    logic        rv1 = 1'b0;
    logic [31:0] rpc1 = 32'h0;
    logic        out_valid1;
    logic        rdy1 = 1'b1;
    logic [31:0] pc_out1;
    logic [31:0] instr_out1;

    logic [31:0] rom0 [4096];
    logic [31:0] rom1 [4096];

    instr_fetch u_dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_req(rom_req), .rom_q(rom_q),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .instr_out(instr_out)
    );

    instr_fetch #(.RESET_PC(32'h0000_3FF8), .DEPTH(4)) u_dut_wrap (
        .clk(clk), .rst(rst1), .rom_addr(rom_addr1), .rom_req(rom_req1), .rom_q(rom_q1),
        .redirect_valid(rv1), .redirect_pc(rpc1),
        .out_valid(out_valid1), .out_ready(rdy1), .pc_out(pc_out1), .instr_out(instr_out1)
    );

    // Synchronous ROMs
    always @(posedge clk) begin
        rom_q  <= rom0[rom_addr];
        rom_q1 <= rom1[rom_addr1];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + {20'h0, pc[13:2]};
    endfunction

    // Reset main DUT; returns at a falling edge with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        #1;
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset rom_req",   {31'h0, rom_req},   32'h0);
        chk("reset rom_addr",  {20'h0, rom_addr},  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic        ereq;
        logic [11:0] erom;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [20];

    logic [31:0] exp_pc;
    int          age;
    logic        exp_v;
    logic        r_rdy;
    logic        r_rv;
    logic [31:0] r_rpc;

    initial begin
        rst = 1'b0;
        rst1 = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 4096; i++) begin
            rom0[i] = 32'h1000_0000 + i;
            rom1[i] = 32'h2000_0000 + i;
        end

        // Cycle-by-cycle table: stream, stall to full, redirect, double redirect
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 12'h000, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 12'h001, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 12'h002, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 12'h003, 32'h4};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 12'h004, 32'h8};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 12'h005, 32'h8};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 12'h006, 32'h8};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 12'h006, 32'h8};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 12'h006, 32'h8};
        tbl[9]  = '{1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 12'h007, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 12'h040, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 12'h041, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 12'h042, 32'h100};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 12'h043, 32'h104};
        tbl[14] = '{1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 12'h044, 32'h0};
        tbl[15] = '{1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 12'h080, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 12'h0C0, 32'h0};
        tbl[17] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 12'h0C1, 32'h0};
        tbl[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 12'h0C2, 32'h300};
        tbl[19] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 12'h0C3, 32'h304};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            out_ready = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc;
            #1;
            chk($sformatf("tbl[%0d] out_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].ev});
            chk($sformatf("tbl[%0d] rom_req", i),   {31'h0, rom_req},   {31'h0, tbl[i].ereq});
            chk($sformatf("tbl[%0d] rom_addr", i),  {20'h0, rom_addr},  {20'h0, tbl[i].erom});
            if (tbl[i].ev) begin
                chk($sformatf("tbl[%0d] pc_out", i),    pc_out,    tbl[i].epc);
                chk($sformatf("tbl[%0d] instr_out", i), instr_out, word_of(tbl[i].epc));
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;

        // Stall for 10 cycles, then drain: 0,4,8,12,16 in order
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 9) begin
                chk("stall rom_req", {31'h0, rom_req}, 32'h0);
                chk("stall out_valid", {31'h0, out_valid}, 32'h1);
                chk("stall head pc", pc_out, 32'h0);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("drain[%0d] out_valid", k), {31'h0, out_valid}, 32'h1);
            chk($sformatf("drain[%0d] pc_out", k), pc_out, 32'(k * 4));
            chk($sformatf("drain[%0d] instr_out", k), instr_out, word_of(32'(k * 4)));
            @(negedge clk);
        end

        // Reset mid-fetch with two entries queued and one in flight
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            @(negedge clk);
        end
        #1;
        chk("pre-rst out_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid-rst out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid-rst rom_req", {31'h0, rom_req}, 32'h0);
        chk("mid-rst rom_addr", {20'h0, rom_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("post-rst[%0d] out_valid", c), {31'h0, out_valid}, (c == 2) ? 32'h1 : 32'h0);
            if (c == 2) begin
                chk("post-rst pc_out", pc_out, 32'h0);
                chk("post-rst instr_out", instr_out, word_of(32'h0));
            end
            @(negedge clk);
        end

        // 16 KiB wrap on the second instance
        rst1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 3) chk($sformatf("wrap rom_addr[%0d]", c), {20'h0, rom_addr1}, (c == 0) ? 32'hFFE : (c == 1) ? 32'hFFF : 32'h000);
            if (c >= 2) begin
                chk($sformatf("wrap out_valid[%0d]", c), {31'h0, out_valid1}, 32'h1);
                chk($sformatf("wrap pc_out[%0d]", c), pc_out1, 32'h0000_3FF8 + 32'((c - 2) * 4));
                chk($sformatf("wrap instr_out[%0d]", c), instr_out1,
                    (c == 2) ? 32'h2000_0FFE : (c == 3) ? 32'h2000_0FFF : 32'h2000_0000);
            end
            @(negedge clk);
        end

        // Randomized run against a transaction-level model: the accepted stream
        // is consecutive PCs from the last restart point, each word read from the
        // ROM image, first valid two edges after restart.
        for (int i = 0; i < 4096; i++) rom0[i] = $urandom;
        do_reset();
        exp_pc = 32'h0;
        age = 0;
        for (int n = 0; n < 3000; n++) begin
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_rpc = $urandom;
            out_ready = r_rdy;
            redirect_valid = r_rv;
            redirect_pc = r_rpc;
            #1;
            exp_v = !r_rv && (age >= 2);
            chk("rand out_valid", {31'h0, out_valid}, {31'h0, exp_v});
            if (r_rv) chk("rand rom_req on redirect", {31'h0, rom_req}, 32'h0);
            if (exp_v) begin
                chk("rand pc_out", pc_out, exp_pc);
                chk("rand instr_out", instr_out, rom0[exp_pc[13:2]]);
            end
            if (r_rv) begin
                exp_pc = r_rpc & 32'hFFFF_FFFC;
                age = 0;
            end else begin
                if (exp_v && r_rdy) exp_pc = exp_pc + 32'd4;
                if (age < 2) age++;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
